// File: rtl/burst_pkg.sv
// Shared constants and state encoding for the DDR write-burst arbiter.
package burst_pkg;

    localparam int DEF_ADDR_W = 27;
    localparam int DEF_DATA_W = 64;
    localparam int LEN_W      = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_RELEASE
    } arb_state_e;

endpackage

// File: rtl/burst_rr_pick.sv
// Two-way picker: a lone requester wins; on a tie the pointer picks (RR) or ch0 wins (fixed).
module burst_rr_pick #(
    parameter int RR_EN = 1
) (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt
);

    logic w_pref1;

    assign w_pref1 = (RR_EN != 0) ? i_ptr : 1'b0;

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = w_pref1 ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/wr_burst_arb.sv
// Arbitrates two write channels onto one DDR write-burst port, with a
// per-burst watchdog that aborts bursts the controller never finishes.
module wr_burst_arb
    import burst_pkg::*;
#(
    parameter int RR_EN   = 1,
    parameter int TIMEOUT = 4096,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic              mem_clk,
    input  logic              rst,
    input  logic              c0_wr_burst_req,
    input  logic [LEN_W-1:0]  c0_wr_burst_len,
    input  logic [ADDR_W-1:0] c0_wr_burst_addr,
    input  logic [DATA_W-1:0] c0_wr_burst_data,
    output logic              c0_wr_burst_data_req,
    output logic              c0_burst_finish,
    input  logic              c1_wr_burst_req,
    input  logic [LEN_W-1:0]  c1_wr_burst_len,
    input  logic [ADDR_W-1:0] c1_wr_burst_addr,
    input  logic [DATA_W-1:0] c1_wr_burst_data,
    output logic              c1_wr_burst_data_req,
    output logic              c1_burst_finish,
    output logic              m_wr_burst_req,
    output logic [LEN_W-1:0]  m_wr_burst_len,
    output logic [ADDR_W-1:0] m_wr_burst_addr,
    output logic [DATA_W-1:0] m_wr_burst_data,
    input  logic              m_wr_burst_data_req,
    input  logic              m_burst_finish,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e        r_state;
    logic [CNT_W-1:0]  r_wdog;
    logic              r_rr_ptr;
    logic              r_owner;
    logic [1:0]        r_fin;

    logic [1:0]        w_req;
    logic [1:0]        w_pick;
    logic [LEN_W-1:0]  w_sel_len;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_active;
    logic              w_busy;
    logic              w_wdog_exp;

    assign w_req = {c1_wr_burst_req, c0_wr_burst_req};

    burst_rr_pick #(.RR_EN(RR_EN)) u_pick (
        .i_req (w_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick)
    );

    assign w_sel_len  = w_pick[1] ? c1_wr_burst_len  : c0_wr_burst_len;
    assign w_sel_addr = w_pick[1] ? c1_wr_burst_addr : c0_wr_burst_addr;
    assign w_active   = (r_state == ST_ISSUE) || (r_state == ST_BUSY);
    assign w_busy     = (r_state == ST_BUSY);
    assign w_wdog_exp = (r_wdog == CNT_W'(TIMEOUT - 1));

    // Controller strobes only reach the owner while a burst is live; strays are dropped.
    assign c0_wr_burst_data_req = m_wr_burst_data_req & grant[0] & w_active;
    assign c1_wr_burst_data_req = m_wr_burst_data_req & grant[1] & w_active;
    assign c0_burst_finish      = (m_burst_finish & grant[0] & w_busy) | r_fin[0];
    assign c1_burst_finish      = (m_burst_finish & grant[1] & w_busy) | r_fin[1];
    assign m_wr_burst_data      = grant[0] ? c0_wr_burst_data :
                                  grant[1] ? c1_wr_burst_data : '0;

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_wdog          <= '0;
            r_rr_ptr        <= 1'b0;
            r_owner         <= 1'b0;
            r_fin           <= '0;
            grant           <= '0;
            m_wr_burst_req  <= 1'b0;
            m_wr_burst_len  <= '0;
            m_wr_burst_addr <= '0;
            timeout_err     <= 1'b0;
        end else begin
            r_fin <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_pick) begin
                        grant           <= w_pick;
                        r_owner         <= w_pick[1];
                        m_wr_burst_len  <= w_sel_len;
                        m_wr_burst_addr <= w_sel_addr;
                        // Zero-length bursts never touch the controller.
                        if (w_sel_len == '0) begin
                            r_fin   <= w_pick;
                            r_state <= ST_RELEASE;
                        end else begin
                            r_wdog  <= '0;
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE, ST_BUSY: begin
                    r_wdog <= r_wdog + CNT_W'(1);
                    if (r_state == ST_ISSUE) begin
                        m_wr_burst_req <= 1'b1;
                        r_state        <= ST_BUSY;
                    end else if (m_wr_burst_data_req) begin
                        m_wr_burst_req <= 1'b0;
                    end
                    if (w_busy && m_burst_finish) begin
                        m_wr_burst_req <= 1'b0;
                        grant          <= '0;
                        r_state        <= ST_RELEASE;
                    end else if (w_wdog_exp) begin
                        timeout_err    <= 1'b1;
                        m_wr_burst_req <= 1'b0;
                        r_fin          <= grant;
                        grant          <= '0;
                        r_state        <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    grant    <= '0;
                    r_rr_ptr <= ~r_owner;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wr_burst_arb.sv
// Directed and randomized checks of wr_burst_arb against a burst-level model;
// a fixed-priority twin runs in lockstep to observe starvation.
module tb_wr_burst_arb;

    logic        mem_clk = 1'b0;
    logic        rst;
    logic [1:0]  c_req;
    logic [9:0]  c_len  [2];
    logic [26:0] c_addr [2];
    logic [63:0] c_data [2];
    logic        m_dreq, m_fin;

    logic [1:0]  rr_dreq, rr_fin, rr_grant;
    logic        rr_mreq, rr_err;
    logic [9:0]  rr_len;
    logic [26:0] rr_addr;
    logic [63:0] rr_data;

    logic [1:0]  fp_dreq, fp_fin, fp_grant;
    logic        fp_mreq, fp_err;
    logic [9:0]  fp_len;
    logic [26:0] fp_addr;
    logic [63:0] fp_data;

    int n_assert = 0;
    int n_fail   = 0;
    int last_ch  = 1;

    always #5 mem_clk = ~mem_clk;

    wr_burst_arb #(.RR_EN(1), .TIMEOUT(16)) u_rr (
        .mem_clk(mem_clk), .rst(rst),
        .c0_wr_burst_req(c_req[0]), .c0_wr_burst_len(c_len[0]), .c0_wr_burst_addr(c_addr[0]),
        .c0_wr_burst_data(c_data[0]), .c0_wr_burst_data_req(rr_dreq[0]), .c0_burst_finish(rr_fin[0]),
        .c1_wr_burst_req(c_req[1]), .c1_wr_burst_len(c_len[1]), .c1_wr_burst_addr(c_addr[1]),
        .c1_wr_burst_data(c_data[1]), .c1_wr_burst_data_req(rr_dreq[1]), .c1_burst_finish(rr_fin[1]),
        .m_wr_burst_req(rr_mreq), .m_wr_burst_len(rr_len), .m_wr_burst_addr(rr_addr),
        .m_wr_burst_data(rr_data), .m_wr_burst_data_req(m_dreq), .m_burst_finish(m_fin),
        .grant(rr_grant), .timeout_err(rr_err)
    );

    wr_burst_arb #(.RR_EN(0), .TIMEOUT(16)) u_fp (
        .mem_clk(mem_clk), .rst(rst),
        .c0_wr_burst_req(c_req[0]), .c0_wr_burst_len(c_len[0]), .c0_wr_burst_addr(c_addr[0]),
        .c0_wr_burst_data(c_data[0]), .c0_wr_burst_data_req(fp_dreq[0]), .c0_burst_finish(fp_fin[0]),
        .c1_wr_burst_req(c_req[1]), .c1_wr_burst_len(c_len[1]), .c1_wr_burst_addr(c_addr[1]),
        .c1_wr_burst_data(c_data[1]), .c1_wr_burst_data_req(fp_dreq[1]), .c1_burst_finish(fp_fin[1]),
        .m_wr_burst_req(fp_mreq), .m_wr_burst_len(fp_len), .m_wr_burst_addr(fp_addr),
        .m_wr_burst_data(fp_data), .m_wr_burst_data_req(m_dreq), .m_burst_finish(m_fin),
        .grant(fp_grant), .timeout_err(fp_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete burst by channel ch, as seen by the controller model.
    // hold=1 keeps the request high afterwards; fp_ch<0 skips the fixed-priority twin.
    task automatic serve(input int ch, input int len, input logic [26:0] addr,
                         input bit hold, input int fp_ch);
        int oc = 1 - ch;
        logic [1:0] g;
        g = 2'b01 << ch;
        c_req[ch]  = 1'b1;
        c_len[ch]  = 10'(len);
        c_addr[ch] = addr;
        @(negedge mem_clk);
        chk("grant", 64'(rr_grant), 64'(g));
        if (fp_ch >= 0) chk("fp_grant", 64'(fp_grant), 64'(2'b01 << fp_ch));
        chk("mreq_at_grant", 64'(rr_mreq), 64'(0));
        // Later input changes must not disturb the latched burst.
        c_len[ch]  = {1'b1, 9'($urandom)};
        c_addr[ch] = 27'($urandom);
        if (len == 0) begin
            chk("fin_len0", 64'(rr_fin), 64'(g));
            if (!hold) c_req[ch] = 1'b0;
            @(negedge mem_clk);
            chk("grant_len0_end", 64'(rr_grant), 64'(0));
            chk("fin_len0_end", 64'(rr_fin), 64'(0));
            chk("mreq_len0", 64'(rr_mreq), 64'(0));
            last_ch = ch;
            return;
        end
        @(negedge mem_clk);
        chk("mreq_issue", 64'(rr_mreq), 64'(1));
        chk("m_addr", 64'(rr_addr), 64'(addr));
        chk("m_len", 64'(rr_len), 64'(len));
        for (int i = 0; i < len; i++) begin
            m_dreq    = 1'b1;
            c_data[0] = {$urandom, $urandom};
            c_data[1] = {$urandom, $urandom};
            #1;
            chk("dreq_own", 64'(rr_dreq[ch]), 64'(1));
            chk("dreq_other", 64'(rr_dreq[oc]), 64'(0));
            chk("m_data", rr_data, c_data[ch]);
            if (i == 0 && !hold) c_req[ch] = 1'b0;
            @(negedge mem_clk);
            chk("mreq_dropped", 64'(rr_mreq), 64'(0));
        end
        m_dreq = 1'b0;
        m_fin  = 1'b1;
        #1;
        chk("fin_own", 64'(rr_fin[ch]), 64'(1));
        chk("fin_other", 64'(rr_fin[oc]), 64'(0));
        @(negedge mem_clk);
        m_fin = 1'b0;
        #1;
        chk("grant_release", 64'(rr_grant), 64'(0));
        chk("fin_release", 64'(rr_fin), 64'(0));
        @(negedge mem_clk);
        last_ch = ch;
    endtask

    initial begin
        int first, pat;
        int l0, l1;
        logic [26:0] a0, a1;

        rst = 1'b1; c_req = '0; m_dreq = 1'b0; m_fin = 1'b0;
        c_len[0] = '0; c_len[1] = '0; c_addr[0] = '0; c_addr[1] = '0;
        c_data[0] = 64'h1111; c_data[1] = 64'h2222;
        repeat (3) @(negedge mem_clk);
        chk("rst_grant", 64'(rr_grant), 64'(0));
        chk("rst_mreq", 64'(rr_mreq), 64'(0));
        chk("rst_len", 64'(rr_len), 64'(0));
        chk("rst_addr", 64'(rr_addr), 64'(0));
        chk("rst_data", rr_data, 64'(0));
        chk("rst_err", 64'(rr_err), 64'(0));
        chk("rst_fin", 64'(rr_fin), 64'(0));
        rst = 1'b0;

        // Stray controller strobes while idle go nowhere.
        m_dreq = 1'b1; m_fin = 1'b1;
        #1;
        chk("stray_fin_idle", 64'(rr_fin), 64'(0));
        chk("stray_dreq_idle", 64'(rr_dreq), 64'(0));
        @(negedge mem_clk);
        chk("stray_grant_idle", 64'(rr_grant), 64'(0));
        m_dreq = 1'b0; m_fin = 1'b0;

        // Single channel, long burst.
        serve(1, 10, 27'h0012340, 1'b0, 1);

        // Both request together and keep requesting: RR alternates, fixed priority starves ch1.
        c_req = 2'b11;
        c_len[1] = 10'd4; c_addr[1] = 27'h0BEEF00;
        serve(0, 3, 27'h0100000, 1'b1, 0);
        serve(1, 4, 27'h0BEEF00, 1'b1, 0);
        serve(0, 2, 27'h0200000, 1'b1, 0);
        c_req = 2'b00;

        // Zero-length burst.
        serve(1, 0, 27'h0000777, 1'b0, 1);

        // Controller never answers: watchdog fires 16 cycles after ISSUE.
        c_req[0] = 1'b1; c_len[0] = 10'd5; c_addr[0] = 27'h0333330;
        @(negedge mem_clk);
        chk("wd_grant", 64'(rr_grant), 64'(2'b01));
        @(negedge mem_clk);
        chk("wd_mreq", 64'(rr_mreq), 64'(1));
        repeat (14) @(negedge mem_clk);
        chk("wd_err_early", 64'(rr_err), 64'(0));
        chk("wd_grant_held", 64'(rr_grant), 64'(2'b01));
        @(negedge mem_clk);
        chk("wd_err", 64'(rr_err), 64'(1));
        chk("wd_fin", 64'(rr_fin), 64'(2'b01));
        chk("wd_grant_rel", 64'(rr_grant), 64'(0));
        chk("wd_mreq_drop", 64'(rr_mreq), 64'(0));
        c_req[0] = 1'b0;
        @(negedge mem_clk);
        m_dreq = 1'b1; m_fin = 1'b1;
        #1;
        chk("wd_late_fin", 64'(rr_fin), 64'(0));
        chk("wd_late_dreq", 64'(rr_dreq), 64'(0));
        m_dreq = 1'b0; m_fin = 1'b0;
        last_ch = 0;
        serve(1, 5, 27'h0444440, 1'b0, 1);
        chk("wd_err_sticky", 64'(rr_err), 64'(1));

        // Request held one cycle past finish is not re-granted.
        serve(1, 3, 27'h0555550, 1'b1, 1);
        c_req[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge mem_clk);
            chk("late_drop_grant", 64'(rr_grant), 64'(0));
            chk("late_drop_mreq", 64'(rr_mreq), 64'(0));
        end

        // Randomized patterns against the burst-level arbitration model.
        for (int it = 0; it < 16; it++) begin
            pat = $urandom_range(1, 3);
            l0 = $urandom_range(1, 8); l1 = $urandom_range(1, 8);
            a0 = 27'($urandom); a1 = 27'($urandom);
            if (pat == 3) begin
                first = 1 - last_ch;
                c_req = 2'b11;
                c_len[0] = 10'(l0); c_addr[0] = a0;
                c_len[1] = 10'(l1); c_addr[1] = a1;
                if (first == 0) begin
                    serve(0, l0, a0, 1'b0, -1);
                    serve(1, l1, a1, 1'b0, -1);
                end else begin
                    serve(1, l1, a1, 1'b0, -1);
                    serve(0, l0, a0, 1'b0, -1);
                end
            end else if (pat == 1) begin
                serve(0, l0, a0, 1'b0, -1);
            end else begin
                serve(1, l1, a1, 1'b0, -1);
            end
        end

        // Reset in the middle of a burst.
        chk("err_before_rst", 64'(rr_err), 64'(1));
        c_req[0] = 1'b1; c_len[0] = 10'd6; c_addr[0] = 27'h05A5A5;
        @(negedge mem_clk);
        @(negedge mem_clk);
        m_dreq = 1'b1;
        @(negedge mem_clk);
        @(negedge mem_clk);
        rst = 1'b1;
        @(negedge mem_clk);
        chk("midrst_grant", 64'(rr_grant), 64'(0));
        chk("midrst_mreq", 64'(rr_mreq), 64'(0));
        chk("midrst_len", 64'(rr_len), 64'(0));
        chk("midrst_addr", 64'(rr_addr), 64'(0));
        chk("midrst_err", 64'(rr_err), 64'(0));
        chk("midrst_dreq", 64'(rr_dreq), 64'(0));
        chk("midrst_data", rr_data, 64'(0));
        c_req = 2'b00; m_dreq = 1'b0; rst = 1'b0;
        last_ch = 1;
        c_req[1] = 1'b1; c_len[1] = 10'd2; c_addr[1] = 27'h0600000;
        serve(0, 2, 27'h0700000, 1'b0, 0);
        serve(1, 2, 27'h0600000, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
